// File: rtl/bomb_pkg.sv
// bomb_pkg: shared constants and types for the per-player bomb-slot controller.
//   SLOTS        number of bomb slots per player
//   COORD_W      bits per coordinate on the packed bomb buses
//   EMPTY_COORD  value an unused slot drives (matches no screen cell)
//   CNT_W        counter width for the default fuse/blast lengths
package bomb_pkg;

  localparam int unsigned SLOTS        = 6;
  localparam int unsigned COORD_W      = 6;
  localparam int unsigned FUSE_MS_DEF  = 3000;
  localparam int unsigned BLAST_MS_DEF = 500;
  localparam int unsigned CNT_W        =
      $clog2(((FUSE_MS_DEF > BLAST_MS_DEF) ? FUSE_MS_DEF : BLAST_MS_DEF) + 1);

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t EMPTY_COORD = '1;

  typedef enum logic [1:0] {
    StIdle,
    StFuse,
    StBlast
  } slot_state_e;

endpackage

// File: rtl/bomb_manager_if.sv
// bomb_manager_if: player-side request signals and the bomb buses read by the
// movement blocks.
//   place                 debounced place-bomb button level
//   player_x, player_y    player cell coordinates
//   bomb_x, bomb_y        packed slot coordinates, slot k at [COORD_W*k+1 +: COORD_W]
//   fuse_mask, blast_mask per-slot phase flags
//   explode               one-cycle pulse per slot entering blast
//   full                  no free slot
// master: the player/movement side; slave: bomb_manager.
interface bomb_manager_if;
  import bomb_pkg::*;

  logic                       place;
  logic [9:0]                 player_x;
  logic [9:0]                 player_y;
  logic [1:SLOTS*COORD_W]     bomb_x;
  logic [1:SLOTS*COORD_W]     bomb_y;
  logic [SLOTS-1:0]           fuse_mask;
  logic [SLOTS-1:0]           blast_mask;
  logic [SLOTS-1:0]           explode;
  logic                       full;

  modport master (
    output place, player_x, player_y,
    input  bomb_x, bomb_y, fuse_mask, blast_mask, explode, full
  );

  modport slave (
    input  place, player_x, player_y,
    output bomb_x, bomb_y, fuse_mask, blast_mask, explode, full
  );

endinterface

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot. IDLE -> FUSE -> BLAST -> IDLE, timed in tick pulses.
//   clk, rst_n       clock, asynchronous active-low reset
//   tick             1 ms enable pulse
//   load             allocate this slot (only honoured while IDLE)
//   load_x, load_y   cell to store on load
//   state            current slot state
//   x, y             stored cell, EMPTY_COORD while IDLE
//   explode          one-cycle pulse on FUSE -> BLAST
//   freeing          this edge returns the slot to IDLE (combinational)
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int unsigned FUSE_MS  = FUSE_MS_DEF,
  parameter int unsigned BLAST_MS = BLAST_MS_DEF,
  parameter int unsigned CntW     = CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        load,
  input  coord_t      load_x,
  input  coord_t      load_y,
  output slot_state_e state,
  output coord_t      x,
  output coord_t      y,
  output logic        explode,
  output logic        freeing
);

  slot_state_e     state_q;
  coord_t          x_q, y_q;
  logic [CntW-1:0] cnt_q;
  logic            explode_q;

  logic last_tick;
  assign last_tick = tick && (cnt_q == CntW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x_q       <= EMPTY_COORD;
      y_q       <= EMPTY_COORD;
      explode_q <= 1'b0;
    end else begin
      explode_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Loading never decrements on the same edge, so the fuse spans
          // exactly FUSE_MS later ticks.
          if (load) begin
            state_q <= StFuse;
            cnt_q   <= CntW'(FUSE_MS);
            x_q     <= load_x;
            y_q     <= load_y;
          end
        end
        StFuse: begin
          if (last_tick) begin
            state_q   <= StBlast;
            cnt_q     <= CntW'(BLAST_MS);
            explode_q <= 1'b1;
          end else if (tick) begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StBlast: begin
          if (last_tick) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= EMPTY_COORD;
            y_q     <= EMPTY_COORD;
          end else if (tick) begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          x_q     <= EMPTY_COORD;
          y_q     <= EMPTY_COORD;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign x       = x_q;
  assign y       = y_q;
  assign explode = explode_q;
  assign freeing = (state_q == StBlast) && last_tick;

endmodule

// File: rtl/bomb_manager.sv
// bomb_manager: per-player bomb controller. Edge-detects the place button,
// rejects out-of-range or duplicate cells, allocates the lowest free slot and
// packs all slot coordinates onto the bomb buses.
//   clk, rst_n   clock, asynchronous active-low reset
//   tick_1ms     1 ms enable pulse
//   bus          slave side of bomb_manager_if (place/player in, buses/masks out)
module bomb_manager
  import bomb_pkg::*;
#(
  parameter int unsigned FUSE_MS  = FUSE_MS_DEF,
  parameter int unsigned BLAST_MS = BLAST_MS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick_1ms,
  bomb_manager_if.slave  bus
);

  localparam int unsigned CntW =
      $clog2(((FUSE_MS > BLAST_MS) ? FUSE_MS : BLAST_MS) + 1);
  localparam int unsigned BusW = SLOTS * COORD_W;
  // All-ones is reserved for empty slots, so a player there cannot place.
  localparam logic [9:0] CoordLimit = 10'((1 << COORD_W) - 1);

  // Resets high so a button held through reset does not place a bomb.
  logic place_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) place_q <= 1'b1;
    else        place_q <= bus.place;
  end

  slot_state_e      st [SLOTS];
  coord_t           sx [SLOTS];
  coord_t           sy [SLOTS];
  logic [SLOTS-1:0] slot_explode;
  logic [SLOTS-1:0] slot_freeing;
  logic [SLOTS-1:0] load;

  coord_t px_low, py_low;
  assign px_low = bus.player_x[COORD_W-1:0];
  assign py_low = bus.player_y[COORD_W-1:0];

  logic req, in_range, dup, accept, found;

  assign req      = bus.place & ~place_q;
  assign in_range = (bus.player_x < CoordLimit) && (bus.player_y < CoordLimit);

  always_comb begin
    dup   = 1'b0;
    found = 1'b0;
    load  = '0;
    // A slot leaving BLAST on this edge no longer blocks its cell.
    for (int k = 0; k < SLOTS; k++) begin
      if (st[k] != StIdle && !slot_freeing[k] && sx[k] == px_low && sy[k] == py_low) begin
        dup = 1'b1;
      end
    end
    accept = req && in_range && !dup;
    // Allocation looks at pre-edge state: a slot freeing now is not free yet.
    for (int k = 0; k < SLOTS; k++) begin
      if (!found && st[k] == StIdle) begin
        found   = 1'b1;
        load[k] = accept;
      end
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    bomb_slot #(
      .FUSE_MS  (FUSE_MS),
      .BLAST_MS (BLAST_MS),
      .CntW     (CntW)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick_1ms),
      .load    (load[g]),
      .load_x  (px_low),
      .load_y  (py_low),
      .state   (st[g]),
      .x       (sx[g]),
      .y       (sy[g]),
      .explode (slot_explode[g]),
      .freeing (slot_freeing[g])
    );
  end

  // Slot 0 sits in the most significant field of the bus.
  logic [BusW-1:0]  bomb_x_pk, bomb_y_pk;
  logic [SLOTS-1:0] fuse_pk, blast_pk, idle_pk;

  always_comb begin
    bomb_x_pk = '0;
    bomb_y_pk = '0;
    fuse_pk   = '0;
    blast_pk  = '0;
    idle_pk   = '0;
    for (int k = 0; k < SLOTS; k++) begin
      bomb_x_pk[BusW-1-COORD_W*k -: COORD_W] = sx[k];
      bomb_y_pk[BusW-1-COORD_W*k -: COORD_W] = sy[k];
      fuse_pk[k]  = (st[k] == StFuse);
      blast_pk[k] = (st[k] == StBlast);
      idle_pk[k]  = (st[k] == StIdle);
    end
  end

  assign bus.bomb_x     = bomb_x_pk;
  assign bus.bomb_y     = bomb_y_pk;
  assign bus.fuse_mask  = fuse_pk;
  assign bus.blast_mask = blast_pk;
  assign bus.explode    = slot_explode;
  assign bus.full       = ~|idle_pk;

endmodule

// File: tb/tb_bomb_manager.sv
module tb_bomb_manager;
  import bomb_pkg::*;

  localparam int unsigned FuseMs  = 4;
  localparam int unsigned BlastMs = 2;
  localparam int unsigned BusW    = SLOTS * COORD_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1ms = 1'b0;

  bomb_manager_if bus_if ();

  bomb_manager #(
    .FUSE_MS  (FuseMs),
    .BLAST_MS (BlastMs)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1ms (tick_1ms),
    .bus      (bus_if.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a slot is described by the tick count at which it was
  // placed; its phase follows from how many ticks have elapsed since then.
  int               m_ticks;
  bit               m_act [SLOTS];
  int               m_t0  [SLOTS];
  int               m_x   [SLOTS];
  int               m_y   [SLOTS];
  bit               m_place_prev;
  logic [SLOTS-1:0] m_explode;

  function automatic int phase_of(int k);
    int e;
    if (!m_act[k]) return 0;
    e = m_ticks - m_t0[k];
    return (e < int'(FuseMs)) ? 1 : 2;
  endfunction

  task automatic model_reset();
    m_ticks      = 0;
    m_place_prev = 1'b1;
    m_explode    = '0;
    for (int k = 0; k < SLOTS; k++) m_act[k] = 1'b0;
  endtask

  task automatic model_edge(input bit pl, input int px, input int py, input bit tk);
    bit req, dup;
    int free_slot;
    req = pl && !m_place_prev;
    m_place_prev = pl;
    free_slot = -1;
    dup = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (phase_of(k) == 0 && free_slot < 0) free_slot = k;
      if (phase_of(k) != 0 && m_x[k] == px && m_y[k] == py &&
          !(tk && (m_ticks - m_t0[k]) == int'(FuseMs + BlastMs) - 1)) dup = 1'b1;
    end
    if (tk) m_ticks++;
    m_explode = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (m_act[k]) begin
        if (tk && (m_ticks - m_t0[k]) == int'(FuseMs)) m_explode[k] = 1'b1;
        if ((m_ticks - m_t0[k]) >= int'(FuseMs + BlastMs)) m_act[k] = 1'b0;
      end
    end
    if (req && free_slot >= 0 && px < 63 && py < 63 && !dup) begin
      m_act[free_slot] = 1'b1;
      m_t0[free_slot]  = m_ticks;
      m_x[free_slot]   = px;
      m_y[free_slot]   = py;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [BusW-1:0]  ebx, eby;
    logic [SLOTS-1:0] efm, ebm;
    logic             efull;
    efull = 1'b1;
    for (int k = 0; k < SLOTS; k++) begin
      ebx[BusW-1-COORD_W*k -: COORD_W] = m_act[k] ? COORD_W'(m_x[k]) : EMPTY_COORD;
      eby[BusW-1-COORD_W*k -: COORD_W] = m_act[k] ? COORD_W'(m_y[k]) : EMPTY_COORD;
      efm[k] = (phase_of(k) == 1);
      ebm[k] = (phase_of(k) == 2);
      if (!m_act[k]) efull = 1'b0;
    end
    checks++;
    if (bus_if.bomb_x !== ebx || bus_if.bomb_y !== eby || bus_if.fuse_mask !== efm ||
        bus_if.blast_mask !== ebm || bus_if.explode !== m_explode || bus_if.full !== efull) begin
      errors++;
      $display("FAIL %s: got x=%h y=%h f=%b b=%b e=%b full=%b expected x=%h y=%h f=%b b=%b e=%b full=%b",
               name, bus_if.bomb_x, bus_if.bomb_y, bus_if.fuse_mask, bus_if.blast_mask,
               bus_if.explode, bus_if.full, ebx, eby, efm, ebm, m_explode, efull);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs checked there too.
  task automatic step(input bit pl, input int px, input int py, input bit tk,
                      input string name = "model");
    bus_if.place    = pl;
    bus_if.player_x = 10'(px);
    bus_if.player_y = 10'(py);
    tick_1ms        = tk;
    @(posedge clk);
    model_edge(pl, px, py, tk);
    #1;
    check_model(name);
  endtask

  task automatic press(input int px, input int py);
    step(1'b1, px, py, 1'b0, "press");
    step(1'b0, px, py, 1'b0, "release");
  endtask

  task automatic drain();
    for (int i = 0; i < int'(FuseMs + BlastMs); i++) step(1'b0, 0, 0, 1'b1, "drain");
  endtask

  task automatic check_reset_values(input string name);
    chk({name, "_bx"}, 64'(bus_if.bomb_x), 64'({BusW{1'b1}}));
    chk({name, "_by"}, 64'(bus_if.bomb_y), 64'({BusW{1'b1}}));
    chk({name, "_masks"}, 64'({bus_if.fuse_mask, bus_if.blast_mask, bus_if.explode,
                               bus_if.full}), 64'(0));
  endtask

  typedef struct {
    logic             place;
    int               px;
    int               py;
    logic             tick;
    logic [SLOTS-1:0] fm;
    logic [SLOTS-1:0] bm;
    logic [SLOTS-1:0] ex;
    logic             full;
    logic [5:0]       x0;
    logic [5:0]       y0;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int px, py, r;
    bit pl, tk;

    // place held high through reset
    bus_if.place    = 1'b1;
    bus_if.player_x = 10'd3;
    bus_if.player_y = 10'd5;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    #3 rst_n = 1'b1;

    // Basic lifecycle at (3,5): held button ignored, placement, duplicate
    // rejection, explode on the 4th tick, free after 2 blast ticks.
    tbl[0]  = '{1'b1, 3, 5, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 6'h3F, 6'h3F};
    tbl[1]  = '{1'b0, 3, 5, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 6'h3F, 6'h3F};
    tbl[2]  = '{1'b1, 3, 5, 1'b0, 6'h01, 6'h00, 6'h00, 1'b0, 6'd3,  6'd5};
    tbl[3]  = '{1'b1, 3, 5, 1'b1, 6'h01, 6'h00, 6'h00, 1'b0, 6'd3,  6'd5};
    tbl[4]  = '{1'b0, 3, 5, 1'b1, 6'h01, 6'h00, 6'h00, 1'b0, 6'd3,  6'd5};
    tbl[5]  = '{1'b1, 3, 5, 1'b0, 6'h01, 6'h00, 6'h00, 1'b0, 6'd3,  6'd5};
    tbl[6]  = '{1'b0, 3, 5, 1'b1, 6'h01, 6'h00, 6'h00, 1'b0, 6'd3,  6'd5};
    tbl[7]  = '{1'b0, 3, 5, 1'b1, 6'h00, 6'h01, 6'h01, 1'b0, 6'd3,  6'd5};
    tbl[8]  = '{1'b0, 3, 5, 1'b0, 6'h00, 6'h01, 6'h00, 1'b0, 6'd3,  6'd5};
    tbl[9]  = '{1'b0, 3, 5, 1'b1, 6'h00, 6'h01, 6'h00, 1'b0, 6'd3,  6'd5};
    tbl[10] = '{1'b0, 3, 5, 1'b1, 6'h00, 6'h00, 6'h00, 1'b0, 6'h3F, 6'h3F};
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].place, tbl[i].px, tbl[i].py, tbl[i].tick, "table_model");
      chk($sformatf("table%0d_fuse", i),  64'(bus_if.fuse_mask),  64'(tbl[i].fm));
      chk($sformatf("table%0d_blast", i), 64'(bus_if.blast_mask), 64'(tbl[i].bm));
      chk($sformatf("table%0d_expl", i),  64'(bus_if.explode),    64'(tbl[i].ex));
      chk($sformatf("table%0d_full", i),  64'(bus_if.full),       64'(tbl[i].full));
      chk($sformatf("table%0d_x0", i),    64'(bus_if.bomb_x[1:6]), 64'(tbl[i].x0));
      chk($sformatf("table%0d_y0", i),    64'(bus_if.bomb_y[1:6]), 64'(tbl[i].y0));
    end

    // Fill all six slots, then a seventh press is dropped.
    for (int k = 0; k < SLOTS; k++) press(10, k);
    chk("six_full", 64'(bus_if.full), 64'(1));
    chk("six_fuse", 64'(bus_if.fuse_mask), 64'(6'h3F));
    press(9, 1);
    chk("seventh_fuse", 64'(bus_if.fuse_mask), 64'(6'h3F));
    chk("seventh_y1", 64'(bus_if.bomb_y[7:12]), 64'(1));
    chk("seventh_x1", 64'(bus_if.bomb_x[7:12]), 64'(10));
    drain();
    chk("drained_full", 64'(bus_if.full), 64'(0));

    // Make slot 2 the oldest, fill the rest, then free it.
    press(20, 1);
    press(20, 2);
    step(1'b0, 0, 0, 1'b1);
    press(20, 3);
    for (int i = 0; i < 5; i++) step(1'b0, 0, 0, 1'b1);
    press(20, 4);
    press(20, 5);
    press(20, 6);
    press(20, 7);
    press(20, 8);
    chk("stagger_full", 64'(bus_if.full), 64'(1));
    chk("stagger_blast2", 64'(bus_if.blast_mask), 64'(6'h04));
    // Slot 2 frees on the same edge as this request: not reused.
    step(1'b1, 9, 1, 1'b1, "free_same_edge");
    chk("same_edge_x2", 64'(bus_if.bomb_x[13:18]), 64'(6'h3F));
    step(1'b0, 9, 1, 1'b0);
    press(21, 7);
    chk("reuse_x2", 64'(bus_if.bomb_x[13:18]), 64'(21));
    chk("reuse_y2", 64'(bus_if.bomb_y[13:18]), 64'(7));
    chk("reuse_full", 64'(bus_if.full), 64'(1));
    drain();

    // Placement coinciding with a tick: fuse still spans 4 later ticks.
    step(1'b1, 30, 30, 1'b1, "place_on_tick");
    chk("tickplace_fuse", 64'(bus_if.fuse_mask), 64'(6'h01));
    for (int i = 0; i < 3; i++) step(1'b0, 30, 30, 1'b1);
    chk("tickplace_no_expl", 64'(bus_if.explode), 64'(0));
    step(1'b0, 30, 30, 1'b1);
    chk("tickplace_expl", 64'(bus_if.explode), 64'(6'h01));
    drain();

    // Reset while slots 0 and 1 are blasting (explode just pulsed).
    press(1, 1);
    press(2, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b1);
    chk("preset_blast", 64'(bus_if.blast_mask), 64'(6'h03));
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    model_reset();
    tick_1ms = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("held_reset");
    #3 rst_n = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      pl = 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      px = (r < 7) ? int'($urandom_range(0, 4)) : (r == 7) ? 62 : (r == 8) ? 63
           : int'($urandom_range(64, 1023));
      r = int'($urandom_range(0, 9));
      py = (r < 8) ? int'($urandom_range(0, 3)) : (r == 8) ? 63 : 62;
      tk = ($urandom_range(0, 2) == 0);
      step(pl, px, py, tk, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bomb_manager.md
# bomb_manager

Bomb-slot controller for one player: accepts the player's "place bomb" button, allocates one of six bomb slots at the player's current cell, runs each bomb's fuse and blast timers, and drives the packed bomb-coordinate buses that the movement blocks (move_man, move_man2) use for collision. One instance per player; it is the writer of the bomb_x/bomb_y buses those blocks read.

## Interface
- SLOTS, 6: number of bomb slots.
- COORD_W, 6: bits per coordinate on the packed buses.
- FUSE_MS, 3000: fuse length in tick_1ms pulses.
- BLAST_MS, 500: blast length in tick_1ms pulses.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tick_1ms  in  1  one-clk-wide enable pulse every 1 ms (from clk1ms, resynchronised).
- place  in  1  debounced place-bomb button level (from pbdebounce).
- player_x, player_y  in  10 each  player cell coordinates (from move_man).
- bomb_x, bomb_y  out  [1:SLOTS*COORD_W] each  packed slot coordinates; slot k at bits [COORD_W*k+1 : COORD_W*k+COORD_W], lower index = MSB.
- fuse_mask  out  SLOTS  slot k in FUSE.
- blast_mask  out  SLOTS  slot k in BLAST.
- explode  out  SLOTS  one-clk pulse, bit k when slot k enters BLAST.
- full  out  1  no IDLE slot.

## Operation
- Per-slot FSM: IDLE -> FUSE -> BLAST -> IDLE. Each slot holds x, y (COORD_W each) and a down-counter wide enough for max(FUSE_MS, BLAST_MS).
- Placement request: place high and place_q low (place_q = place registered). place_q resets to 1, so a button held through reset places nothing.
- Request accepted only if: some slot IDLE; player_x and player_y both < 2**COORD_W - 1; no FUSE/BLAST slot already holds (player_x, player_y). Otherwise dropped silently, no retry.
- Accepted: lowest-index IDLE slot loads player coordinates (low COORD_W bits), counter = FUSE_MS, state FUSE.
- FUSE: counter decrements on tick_1ms. On tick_1ms with counter == 1: state BLAST, counter = BLAST_MS, explode[k] = 1 for that one cycle.
- BLAST: counter decrements on tick_1ms. On tick_1ms with counter == 1: state IDLE.
- Bus contents: FUSE or BLAST slot drives its stored x, y (cell stays blocked during blast); IDLE slot drives all-ones (6'h3F), which no screen cell matches (max 39 x 29).
- No chain reactions; blast-to-player and blast-to-bomb interaction is handled downstream.

## Timing
- All outputs registered. Reset: all slots IDLE, bomb_x/bomb_y all ones, fuse_mask = blast_mask = explode = 0, full = 0, counters 0.
- Placement: request true in cycle N -> bus, fuse_mask and full updated after edge N+1 (visible cycle N+1).
- A placement does not decrement on its own edge even if tick_1ms is high; fuse covers exactly FUSE_MS subsequent ticks.
- explode[k] and blast_mask[k] rise on the same edge; explode falls next cycle.
- Slot freed on the same edge as a placement request: allocation uses pre-edge state, so the freed slot is not reused that cycle; freed coordinates do not block the request.
- Multiple slots may expire on one tick; explode carries all their bits together.
- Reset asserted mid-fuse/blast: all slots immediately IDLE, no explode pulse.

## Structure
- Package bomb_pkg: SLOTS, COORD_W, EMPTY_COORD (all ones), slot-state typedef (IDLE, FUSE, BLAST), counter width constant.
- Sub-module bomb_slot: one slot's FSM, counter, and coordinate registers; inputs load, load_x, load_y, tick; outputs state, x, y, explode. Top level (generate loop) holds edge detect, duplicate check, priority allocator, bus packing.

## Test plan
- Reset with place held high -> bus all ones, masks 0, no slot allocated until place goes low then high.
- FUSE_MS=4, BLAST_MS=2; place at (3,5) -> bomb_x[1:6]=3, bomb_y[1:6]=5, fuse_mask=000001; explode[0] pulses one cycle on 4th tick; after 2 more ticks slot returns to 6'h3F.
- Second press at same cell (3,5) while slot 0 in FUSE -> rejected, fuse_mask unchanged.
- Six presses at distinct cells -> full=1, fuse_mask=111111; seventh press at (9,1) rejected; after slot 2 frees, next press lands in slot 2.
- Placement on same cycle as tick_1ms -> counter still FUSE_MS after that edge; explode on FUSE_MS-th later tick.
- rst_n pulsed low while slot 1 in BLAST -> immediate return to reset values, no explode pulse.
